// File: rtl/mdio_slave_bridge_pkg.sv
// Shared definitions for the MDIO management slave: frame states, opcodes,
// preamble length and the bus request record passed to the master side.
package mdio_slave_bridge_pkg;

   typedef enum logic [2:0] {
      S_PRE,
      S_ST2,
      S_OP,
      S_PHY,
      S_REG,
      S_TA,
      S_DATA,
      S_SKIP
   } mdioState_t;

   localparam logic [1:0]  cMdioOpRead    = 2'b10;
   localparam logic [1:0]  cMdioOpWrite   = 2'b01;
   localparam int          cPreambleLen   = 32;
   localparam logic [4:0]  cPreambleLast  = 5'(cPreambleLen - 1);
   localparam logic [15:0] cRdDataDefault = 16'hFFFF;

   // Skip loads hold (remaining bits - 1): PHY+REG+TA+DATA after OP, TA+DATA after REG.
   localparam logic [4:0]  cSkipAfterOp   = 5'd27;
   localparam logic [4:0]  cSkipAfterReg  = 5'd17;

   typedef struct packed {
      logic        wEn;
      logic [4:0]  regAd;
      logic [15:0] data;
   } busReq_t;

   function automatic logic [7:0] regByteAddr(input logic [4:0] regAd);
      return {1'b0, regAd, 2'b00};
   endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// MDC/MDIO pad synchronizers of equal depth plus a registered MDC rising-edge
// strobe; the sampled MDIO bit is aligned to that strobe.
module mdio_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_Clk,
   input  logic w_ARstLogic_L,
   input  logic i_Mdc,
   input  logic i_MdioIn,
   output logic o_MdcRise,
   output logic o_MdioBit
);

   logic [SYNC_STAGES-1:0] mdcSync;
   logic [SYNC_STAGES-1:0] mdioSync;
   logic                   mdcPrev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_Clk or negedge w_ARstLogic_L) begin
      if (!w_ARstLogic_L) begin
         mdcSync   <= '0;
         mdioSync  <= '1;
         mdcPrev   <= 1'b0;
         o_MdcRise <= 1'b0;
         o_MdioBit <= 1'b1;
      end else begin
         mdcSync   <= {mdcSync[SYNC_STAGES-2:0], i_Mdc};
         mdioSync  <= {mdioSync[SYNC_STAGES-2:0], i_MdioIn};
         mdcPrev   <= mdcSync[SYNC_STAGES-1];
         o_MdcRise <= mdcSync[SYNC_STAGES-1] & ~mdcPrev;
         o_MdioBit <= mdioSync[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/mdio_slave_bridge.sv
// Clause-22 MDIO slave bridging frames onto single local-bus accesses.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN accepts a start after a single preamble 1.
module mdio_slave_bridge
   import mdio_slave_bridge_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR    = 5'd0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        i_Clk,
   input  logic        w_ARstLogic_L,
   input  logic        i_Mdc,
   input  logic        i_MdioIn,
   output logic        o_MdioOut,
   output logic        o_MdioOe,
   output logic        o_Cyc,
   output logic        o_Stb,
   output logic        o_WEn,
   output logic [7:0]  o8_Addr,
   output logic [31:0] o32_WrData,
   input  logic [31:0] i32_RdData,
   input  logic        i_Ack,
   input  logic        i_Stall,
   output logic        o_FrameErr
);

   logic        mdcRise, mdioBit;
   mdioState_t  state, stateNext;
   logic [4:0]  bitCnt, cntNext;
   logic [15:0] shiftReg;
   logic        preOk, preOkNext;
   logic        isRead, isReadNext;
   logic        phyOk, phyOkNext;
   logic [4:0]  regAd, regAdNext;
   logic [15:0] outShift, outShiftNext;
   logic        oeNext, outNext, frameErrNext;
   logic        launchRd, launchWr, rdTimeout;
   logic [4:0]  fieldBits;
   logic [15:0] wordBits;
   logic [15:0] rdData;
   logic        rdValid, rdStale;
   logic        qValid;
   busReq_t     qReq, launchReq, issueReq;
   logic        unusedBits;

   mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncEdge (
      .i_Clk         (i_Clk),
      .w_ARstLogic_L (w_ARstLogic_L),
      .i_Mdc         (i_Mdc),
      .i_MdioIn      (i_MdioIn),
      .o_MdcRise     (mdcRise),
      .o_MdioBit     (mdioBit)
   );

   assign fieldBits  = {shiftReg[3:0], mdioBit};
   assign wordBits   = {shiftReg[14:0], mdioBit};
   assign o_Stb      = o_Cyc;
   assign unusedBits = &{1'b0, i_Stall, i32_RdData[31:16]};

   always_ff @(posedge i_Clk or negedge w_ARstLogic_L) begin
      if (!w_ARstLogic_L) begin
         state      <= S_PRE;
         bitCnt     <= '0;
         shiftReg   <= '0;
         preOk      <= 1'b0;
         isRead     <= 1'b0;
         phyOk      <= 1'b0;
         regAd      <= '0;
         outShift   <= cRdDataDefault;
         o_MdioOe   <= 1'b0;
         o_MdioOut  <= 1'b1;
         o_FrameErr <= 1'b0;
      end else begin
         state      <= stateNext;
         bitCnt     <= cntNext;
         preOk      <= preOkNext;
         isRead     <= isReadNext;
         phyOk      <= phyOkNext;
         regAd      <= regAdNext;
         outShift   <= outShiftNext;
         o_MdioOe   <= oeNext;
         o_MdioOut  <= outNext;
         o_FrameErr <= frameErrNext;
         if (mdcRise) shiftReg <= wordBits;
      end
   end

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      stateNext    = state;
      cntNext      = bitCnt;
      preOkNext    = preOk;
      isReadNext   = isRead;
      phyOkNext    = phyOk;
      regAdNext    = regAd;
      outShiftNext = outShift;
      oeNext       = o_MdioOe;
      outNext      = o_MdioOut;
      frameErrNext = 1'b0;
      launchRd     = 1'b0;
      launchWr     = 1'b0;
      rdTimeout    = 1'b0;
      if (mdcRise) begin
         case (state)
            S_PRE: begin
               if (mdioBit) begin
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                  preOkNext = 1'b1;
`else
                  if (bitCnt == cPreambleLast) preOkNext = 1'b1;
                  else                         cntNext   = bitCnt + 5'd1;
`endif
               end else begin
                  cntNext   = '0;
                  preOkNext = 1'b0;
                  if (preOk) stateNext = S_ST2;
               end
            end
            S_ST2: begin
               cntNext = '0;
               if (mdioBit) stateNext = S_OP;
               else begin
                  frameErrNext = 1'b1;
                  stateNext    = S_PRE;
               end
            end
            S_OP: begin
               if (bitCnt == 5'd0) cntNext = 5'd1;
               else if (fieldBits[1:0] == cMdioOpRead || fieldBits[1:0] == cMdioOpWrite) begin
                  cntNext    = '0;
                  isReadNext = (fieldBits[1:0] == cMdioOpRead);
                  stateNext  = S_PHY;
               end else begin
                  frameErrNext = 1'b1;
                  cntNext      = cSkipAfterOp;
                  stateNext    = S_SKIP;
               end
            end
            S_PHY: begin
               if (bitCnt == 5'd4) begin
                  phyOkNext = (fieldBits == PHY_ADDR);
                  cntNext   = '0;
                  stateNext = S_REG;
               end else cntNext = bitCnt + 5'd1;
            end
            S_REG: begin
               if (bitCnt == 5'd4) begin
                  regAdNext = fieldBits;
                  if (phyOk) begin
                     cntNext   = '0;
                     stateNext = S_TA;
                     launchRd  = isRead;
                  end else begin
                     cntNext   = cSkipAfterReg;
                     stateNext = S_SKIP;
                  end
               end else cntNext = bitCnt + 5'd1;
            end
            S_TA: begin
               if (bitCnt == 5'd0) begin
                  cntNext = 5'd1;
                  if (isRead) begin
                     // A read that has not completed by now is answered with all ones.
                     oeNext       = 1'b1;
                     outNext      = 1'b0;
                     outShiftNext = rdValid ? rdData : cRdDataDefault;
                     rdTimeout    = ~rdValid;
                  end
               end else begin
                  cntNext   = '0;
                  stateNext = S_DATA;
                  if (isRead) begin
                     outNext      = outShift[15];
                     outShiftNext = {outShift[14:0], 1'b1};
                  end
               end
            end
            S_DATA: begin
               if (bitCnt == 5'd15) begin
                  cntNext   = '0;
                  stateNext = S_PRE;
                  launchWr  = ~isRead;
                  if (isRead) begin
                     oeNext  = 1'b0;
                     outNext = 1'b1;
                  end
               end else begin
                  cntNext = bitCnt + 5'd1;
                  if (isRead) begin
                     outNext      = outShift[15];
                     outShiftNext = {outShift[14:0], 1'b1};
                  end
               end
            end
            S_SKIP: begin
               if (bitCnt == 5'd0) stateNext = S_PRE;
               else                cntNext   = bitCnt - 5'd1;
            end
            default: begin
               stateNext = S_PRE;
               cntNext   = '0;
            end
         endcase
      end
   end

   assign launchReq = '{wEn: launchWr, regAd: regAdNext, data: launchWr ? wordBits : 16'h0};
   assign issueReq  = qValid ? qReq : launchReq;

   // Bus master: one access in flight, one-deep queue, outputs dropped the cycle after ack.
   always_ff @(posedge i_Clk or negedge w_ARstLogic_L) begin
      if (!w_ARstLogic_L) begin
         o_Cyc      <= 1'b0;
         o_WEn      <= 1'b0;
         o8_Addr    <= '0;
         o32_WrData <= '0;
         rdData     <= cRdDataDefault;
         rdValid    <= 1'b0;
         rdStale    <= 1'b0;
         qValid     <= 1'b0;
         qReq       <= '0;
      end else begin
         if (rdTimeout) rdStale <= 1'b1;
         if (launchRd)  rdValid <= 1'b0;
         if (o_Cyc) begin
            if (i_Ack) begin
               o_Cyc      <= 1'b0;
               o_WEn      <= 1'b0;
               o8_Addr    <= '0;
               o32_WrData <= '0;
               if (!o_WEn) begin
                  rdStale <= 1'b0;
                  if (!rdStale && !rdTimeout) begin
                     rdData  <= i32_RdData[15:0];
                     rdValid <= 1'b1;
                  end
               end
            end
         end else if (qValid || launchRd || launchWr) begin
            o_Cyc      <= 1'b1;
            o_WEn      <= issueReq.wEn;
            o8_Addr    <= regByteAddr(issueReq.regAd);
            o32_WrData <= {16'h0, issueReq.data};
         end
         if ((launchRd || launchWr) && (o_Cyc || qValid)) begin
            qValid <= 1'b1;
            qReq   <= launchReq;
         end else if (!o_Cyc && qValid) begin
            qValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mdio_slave_bridge.sv
// Directed bench for mdio_slave_bridge: bit-level MDC/MDIO station manager plus a
// bus responder with programmable ack latency; expected values are hand-computed.
`timescale 1ns/1ps
module tb_mdio_slave_bridge;

   logic        i_Clk;
   logic        w_ARstLogic_L;
   logic        i_Mdc, i_MdioIn;
   logic        o_MdioOut, o_MdioOe;
   logic        o_Cyc, o_Stb, o_WEn;
   logic [7:0]  o8_Addr;
   logic [31:0] o32_WrData;
   logic [31:0] i32_RdData;
   logic        i_Ack, i_Stall;
   logic        o_FrameErr;

   int          checkCnt = 0;
   int          failCnt  = 0;
   int          reqCount = 0;
   int          errCount = 0;
   int          holdErr  = 0;
   int          oeCycles = 0;
   int          ackLatency = 3;
   logic [31:0] rdValue = '0;
   logic        capWEn;
   logic [7:0]  capAddr;
   logic [31:0] capWrData;
   int          base, eBase, oeBase, shortPre, shortExp;

   mdio_slave_bridge #(.PHY_ADDR(5'd0), .SYNC_STAGES(2)) dut (
      .i_Clk         (i_Clk),
      .w_ARstLogic_L (w_ARstLogic_L),
      .i_Mdc         (i_Mdc),
      .i_MdioIn      (i_MdioIn),
      .o_MdioOut     (o_MdioOut),
      .o_MdioOe      (o_MdioOe),
      .o_Cyc         (o_Cyc),
      .o_Stb         (o_Stb),
      .o_WEn         (o_WEn),
      .o8_Addr       (o8_Addr),
      .o32_WrData    (o32_WrData),
      .i32_RdData    (i32_RdData),
      .i_Ack         (i_Ack),
      .i_Stall       (i_Stall),
      .o_FrameErr    (o_FrameErr)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         failCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus responder and event monitor, sampling on the falling edge.
   initial begin
      logic prevCyc;
      int   waitCnt;
      prevCyc    = 1'b0;
      waitCnt    = 0;
      i_Ack      = 1'b0;
      i_Stall    = 1'b0;
      i32_RdData = '0;
      forever begin
         @(negedge i_Clk);
         i_Ack = 1'b0;
         if (o_FrameErr) errCount++;
         if (o_MdioOe)   oeCycles++;
         if (o_Cyc) begin
            if (!prevCyc) begin
               reqCount++;
               capWEn    = o_WEn;
               capAddr   = o8_Addr;
               capWrData = o32_WrData;
               waitCnt   = 0;
            end else if (o_WEn !== capWEn || o8_Addr !== capAddr || o32_WrData !== capWrData) begin
               holdErr++;
            end
            if (o_Stb !== 1'b1) holdErr++;
            waitCnt++;
            if (waitCnt == ackLatency) begin
               i_Ack      = 1'b1;
               i32_RdData = rdValue;
            end
         end
         prevCyc = o_Cyc;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic waitClks(input int n);
      repeat (n) @(negedge i_Clk);
   endtask

   // One MDC period (16 i_Clk); slave outputs sampled just before the rising edge.
   task automatic mdcBit(input logic b, output logic sOut, output logic sOe);
      i_MdioIn = b;
      i_Mdc    = 1'b0;
      waitClks(8);
      sOut  = o_MdioOut;
      sOe   = o_MdioOe;
      i_Mdc = 1'b1;
      waitClks(8);
   endtask

   task automatic sendBits(input logic [31:0] v, input int n);
      logic dOut, dOe;
      for (int i = n - 1; i >= 0; i--) mdcBit(v[i], dOut, dOe);
   endtask

   task automatic sendHeader(input int preLen, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] rg);
      for (int i = 0; i < preLen; i++) sendBits(32'h1, 1);
      sendBits({18'h0, 2'b01, op, phy, rg}, 14);
   endtask

   task automatic writeFrame(input logic [4:0] phy, input logic [4:0] rg,
                             input logic [15:0] data, input int preLen);
      sendHeader(preLen, 2'b01, phy, rg);
      sendBits({14'h0, 2'b10, data}, 18);
   endtask

   task automatic readFrame(input logic [4:0] rg, input logic [15:0] expData, input string tag);
      logic        sOut, sOe, allOe;
      logic [15:0] got;
      sendHeader(32, 2'b10, 5'd0, rg);
      mdcBit(1'b1, sOut, sOe);
      check({tag, "_ta1_oe"}, sOe, 1'b0);
      mdcBit(1'b1, sOut, sOe);
      check({tag, "_ta2_oe_out"}, {sOe, sOut}, 2'b10);
      got   = '0;
      allOe = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mdcBit(1'b1, sOut, sOe);
         got   = {got[14:0], sOut};
         allOe = allOe & sOe;
      end
      check({tag, "_data"}, got, expData);
      check({tag, "_data_oe"}, allOe, 1'b1);
      mdcBit(1'b1, sOut, sOe);
      check({tag, "_release_oe"}, sOe, 1'b0);
   endtask

   initial begin
      logic sOut, sOe;
      w_ARstLogic_L = 1'b0;
      i_Mdc         = 1'b0;
      i_MdioIn      = 1'b1;
      waitClks(3);
      check("rst_oe",    o_MdioOe,   1'b0);
      check("rst_out",   o_MdioOut,  1'b1);
      check("rst_cyc",   o_Cyc,      1'b0);
      check("rst_stb",   o_Stb,      1'b0);
      check("rst_wen",   o_WEn,      1'b0);
      check("rst_addr",  o8_Addr,    8'h00);
      check("rst_wdata", o32_WrData, 32'h0);
      check("rst_ferr",  o_FrameErr, 1'b0);
      w_ARstLogic_L = 1'b1;
      waitClks(4);

      // Write PHY 0 / REG 4 / 0x01A0
      ackLatency = 2; base = reqCount; oeBase = oeCycles;
      writeFrame(5'd0, 5'd4, 16'h01A0, 32);
      waitClks(20);
      check("wr_count", reqCount - base, 1);
      check("wr_wen",   capWEn, 1'b1);
      check("wr_addr",  capAddr, 8'h10);
      check("wr_data",  capWrData, 32'h0000_01A0);
      check("wr_no_oe", oeCycles - oeBase, 0);

      // Read REG 1, acked after 3 cycles
      ackLatency = 3; rdValue = 32'h0000_002C; base = reqCount;
      readFrame(5'd1, 16'h002C, "rd1");
      check("rd1_count", reqCount - base, 1);
      check("rd1_wen",   capWEn, 1'b0);
      check("rd1_addr",  capAddr, 8'h04);

      // Read REG 2 with ack withheld ~3 MDC periods: all ones, late ack discarded
      ackLatency = 48; rdValue = 32'h0000_1234; base = reqCount;
      readFrame(5'd2, 16'hFFFF, "rdto");
      waitClks(100);
      check("rdto_count", reqCount - base, 1);
      check("rdto_addr",  capAddr, 8'h08);
      ackLatency = 3; rdValue = 32'hABCD_5A5A; base = reqCount;
      readFrame(5'd3, 16'h5A5A, "rdnext");
      check("rdnext_count", reqCount - base, 1);

      // Foreign PHY address, then an immediately following valid frame
      base = reqCount; oeBase = oeCycles;
      sendHeader(32, 2'b10, 5'd5, 5'd1);
      sendBits(32'h3FFFF, 18);
      check("phy5_count", reqCount - base, 0);
      check("phy5_no_oe", oeCycles - oeBase, 0);
      ackLatency = 2;
      writeFrame(5'd0, 5'd6, 16'h5555, 32);
      waitClks(20);
      check("after_phy5_count", reqCount - base, 1);
      check("after_phy5_addr",  capAddr, 8'h18);
      check("after_phy5_data",  capWrData, 32'h0000_5555);

      // Malformed start and opcode
      eBase = errCount; base = reqCount;
      sendBits(32'hFFFF_FFFF, 32);
      sendBits(32'h0, 2);
      waitClks(10);
      check("st_err", errCount - eBase, 1);
      sendBits(32'hFFFF_FFFF, 32);
      sendBits(32'h7, 4);
      waitClks(10);
      check("op_err", errCount - eBase, 2);
      sendBits(32'h0, 28);
      check("err_no_bus", reqCount - base, 0);

      // Short preamble frame
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      shortPre = 1;  shortExp = 1;
`else
      shortPre = 31; shortExp = 0;
`endif
      base = reqCount; eBase = errCount;
      writeFrame(5'd0, 5'd4, 16'h01A0, shortPre);
      waitClks(20);
      check("short_pre_count", reqCount - base, shortExp);
      check("short_pre_no_err", errCount - eBase, 0);

      // Reset during the read data phase
      ackLatency = 1000; base = reqCount;
      sendHeader(32, 2'b10, 5'd0, 5'd7);
      for (int i = 0; i < 6; i++) mdcBit(1'b1, sOut, sOe);
      check("rst_mid_pre_oe",  o_MdioOe, 1'b1);
      check("rst_mid_pre_cyc", o_Cyc, 1'b1);
      #2;
      w_ARstLogic_L = 1'b0;
      i_Mdc         = 1'b0;
      #1;
      check("rst_mid_oe",   o_MdioOe, 1'b0);
      check("rst_mid_out",  o_MdioOut, 1'b1);
      check("rst_mid_cyc",  o_Cyc, 1'b0);
      check("rst_mid_stb",  o_Stb, 1'b0);
      check("rst_mid_addr", o8_Addr, 8'h00);
      waitClks(5);
      w_ARstLogic_L = 1'b1;
      waitClks(5);
      ackLatency = 2; base = reqCount;
      writeFrame(5'd0, 5'd9, 16'hC0DE, 32);
      waitClks(20);
      check("post_rst_count", reqCount - base, 1);
      check("post_rst_addr",  capAddr, 8'h24);
      check("post_rst_data",  capWrData, 32'h0000_C0DE);
      check("bus_hold_stable", holdErr, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCnt, failCnt);
      $finish;
   end

endmodule
